// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the state encodings, the frame constants and the bit-period helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  // clk cycles per serial bit
  function automatic int bit_cycles(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side byte handshake of the UART transmitter.
// The host drives data_in/send; the transmitter reports ready/busy.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 send;
  logic                 ready;
  logic                 busy;

  modport master (
    output data_in,
    output send,
    input  ready,
    input  busy
  );

  modport slave (
    input  data_in,
    input  send,
    output ready,
    output busy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..BIT-1 and wraps.
// bit_end pulses for one cycle on the last count of each bit.
module uart_baud_cnt #(
  parameter int BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (BIT > 2) ? $clog2(BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  // count while enabled; clear on reset, explicit clear or wrap
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, 1 stop bit, 1-byte holding reg.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_frequency = 50000000,
  parameter int baud_rate     = 9600
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      TX
);

  localparam int BIT = bit_cycles(clk_frequency, baud_rate);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           idx;
  logic                 tx_q;
  logic                 busy_q;
  logic                 ready_q;

  logic accept;
  logic load;
  logic hold_nxt;
  logic bit_end;

  assign accept   = bus.send & ready_q;
  assign load     = hold_full &
                    ((state == S_IDLE) |
                     ((state == S_STOP) & bit_end));
  assign hold_nxt = accept | (hold_full & ~load);

  assign TX        = tx_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;

  uart_baud_cnt #(
    .BIT (BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (load),
    .en      (state != S_IDLE),
    .bit_end (bit_end)
  );

  // holding register and shifter FSM with registered line/status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      idx       <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      hold_full <= hold_nxt;
      ready_q   <= ~hold_nxt;
      if (accept) begin
        hold <= bus.data_in;
      end
      if (load) begin
        state  <= S_START;
        shift  <= hold;
        idx    <= '0;
        tx_q   <= 1'b0;
        busy_q <= 1'b1;
      end else if (bit_end) begin
        unique case (state)
          S_START: begin
            state <= S_DATA;
            tx_q  <= shift[0];
          end
          S_DATA: begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= ^shift;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              idx  <= idx + 3'd1;
              tx_q <= shift[idx + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            tx_q  <= 1'b1;
          end
`endif
          S_STOP: begin
            state  <= S_IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with BIT = 10.
// Outputs are sampled on the falling clock edge.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BIT = 10;

  logic clk = 1'b0;
  logic reset;
  logic TX;

  int vectors = 0;
  int errors  = 0;

  uart_tx_if bus ();

  uart_tx #(
    .clk_frequency (1000),
    .baud_rate     (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .TX    (TX)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // checks one whole frame starting at the first start-bit sample
  task automatic frame(string tag, logic [7:0] d, int drop_at,
                       logic [7:0] junk);
    int   b;
    logic lvl;
    for (int k = 0; k < NB * BIT; k++) begin
      if (k == drop_at) bus.send = 1'b0;
      if (k == 1) bus.data_in = junk;
      b = k / BIT;
      if (b == 0) lvl = 1'b0;
      else if (b <= 8) lvl = d[b-1];
      else if (NB == 11 && b == 9) lvl = ^d;
      else lvl = 1'b1;
      chk($sformatf("%s tx k%0d", tag, k), {7'd0, TX}, {7'd0, lvl});
      chk($sformatf("%s busy k%0d", tag, k), {7'd0, bus.busy}, 8'd1);
      nxt();
    end
  endtask

  initial begin
    bus.send    = 1'b0;
    bus.data_in = 8'h00;
    reset       = 1'b0;
    repeat (3) nxt();
    chk("rst tx", {7'd0, TX}, 8'd1);
    chk("rst ready", {7'd0, bus.ready}, 8'd1);
    chk("rst busy", {7'd0, bus.busy}, 8'd0);
    reset = 1'b1;
    nxt();

    // single frame 0x55
    bus.data_in = 8'h55;
    bus.send    = 1'b1;
    nxt();
    bus.send = 1'b0;
    chk("55 ready n1", {7'd0, bus.ready}, 8'd0);
    chk("55 busy n1", {7'd0, bus.busy}, 8'd0);
    chk("55 tx n1", {7'd0, TX}, 8'd1);
    nxt();
    chk("55 ready n2", {7'd0, bus.ready}, 8'd1);
    frame("55", 8'h55, 0, 8'h00);
    chk("55 busy end", {7'd0, bus.busy}, 8'd0);
    chk("55 tx end", {7'd0, TX}, 8'd1);

    // back-to-back 0xA3 then 0x0F, send held while ready=0
    repeat (3) nxt();
    bus.data_in = 8'hA3;
    bus.send    = 1'b1;
    nxt();
    bus.send = 1'b0;
    nxt();
    bus.data_in = 8'h0F;
    bus.send    = 1'b1;
    frame("a3", 8'hA3, 60, 8'hFF);
    frame("0f", 8'h0F, 0, 8'h00);
    chk("b2b busy end", {7'd0, bus.busy}, 8'd0);
    chk("b2b ready end", {7'd0, bus.ready}, 8'd1);
    repeat (20) nxt();
    chk("b2b no 3rd tx", {7'd0, TX}, 8'd1);
    chk("b2b no 3rd busy", {7'd0, bus.busy}, 8'd0);

    // reset in the middle of the data bits of 0x00
    bus.data_in = 8'h00;
    bus.send    = 1'b1;
    nxt();
    bus.send = 1'b0;
    nxt();
    repeat (35) nxt();
    chk("abort pre tx", {7'd0, TX}, 8'd0);
    chk("abort pre busy", {7'd0, bus.busy}, 8'd1);
    reset = 1'b0;
    nxt();
    chk("abort tx", {7'd0, TX}, 8'd1);
    chk("abort ready", {7'd0, bus.ready}, 8'd1);
    chk("abort busy", {7'd0, bus.busy}, 8'd0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nxt();
      chk($sformatf("abort idle tx %0d", i), {7'd0, TX}, 8'd1);
    end
    chk("abort idle busy", {7'd0, bus.busy}, 8'd0);

`ifdef UART_TX_PARITY_EN
    // parity frames: 0x07 -> 1, 0x03 -> 0
    bus.data_in = 8'h07;
    bus.send    = 1'b1;
    nxt();
    bus.send = 1'b0;
    nxt();
    frame("p07", 8'h07, 0, 8'h00);
    chk("p07 busy end", {7'd0, bus.busy}, 8'd0);
    repeat (2) nxt();
    bus.data_in = 8'h03;
    bus.send    = 1'b1;
    nxt();
    bus.send = 1'b0;
    nxt();
    frame("p03", 8'h03, 0, 8'h00);
    chk("p03 busy end", {7'd0, bus.busy}, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, 8 data bits LSB first, 1 stop bit, optional even parity. It is the transmit-side counterpart of the team's UART receive controller and uses the same `clk_frequency`/`baud_rate` timing model, so a `uart_tx` and a receiver built with equal parameters interoperate. A one-byte holding register decouples the host handshake from the serial shifter, which allows back-to-back frames with no idle gap.

## Interface
- `clk_frequency`, default 50000000: `clk` frequency in Hz.
- `baud_rate`, default 9600: serial bit rate.
- `BIT` (derived), value `clk_frequency/baud_rate` (integer division): cycles per serial bit. Must be ≥ 2.
- `clk` input, 1 bit: single clock; all logic on posedge.
- `reset` input, 1 bit: synchronous reset, active-low (0 = reset).
- `data_in` input, 8 bits: byte to transmit; sampled only on an accepted `send`.
- `send` input, 1 bit: host request. Accepted on any posedge where `send=1` and `ready=1`.
- `ready` output, 1 bit: holding register empty; a new byte may be offered.
- `busy` output, 1 bit: shifter is not in IDLE (a frame is on the line).
- `TX` output, 1 bit: serial line. Connect it to the RX of the other module.

## Operation
- Reset (`reset=0` at a posedge): `TX=1`, `ready=1`, `busy=0`. The shifter goes to IDLE, the holding register is emptied, and the bit counter is cleared. A reset mid-frame aborts the frame immediately, and `TX` is 1 from the next cycle.
- Accept: when `send & ready`, `data_in` is copied into the hold register and `ready=0` from the next cycle. `send` while `ready=0` is ignored and no data is lost.
- Shifter states:
  - IDLE: `TX=1`. If hold is full, go to START, load the shift register from hold, and empty hold (`ready=1` next cycle).
  - START: `TX=0` for `BIT` cycles, then DATA with bit index 0.
  - DATA: `TX=shift[idx]` for `BIT` cycles per bit, bits 0..7. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: `TX=^shift` (even parity) for `BIT` cycles, then STOP.
  - STOP: `TX=1` for `BIT` cycles. At the end of the stop bit, if hold is full, go directly to START and load as in IDLE, with no idle cycle. Otherwise go to IDLE.
- The counter counts 0..`BIT-1` and wraps to 0 on each bit boundary. Its width is `$clog2(BIT)`.
- Simultaneous events: a load from hold and an accept of new `send` cannot coincide, because `ready=0` whenever hold is full. An accept in the same cycle as the last STOP cycle leaves hold full at the next edge, so that byte starts one cycle later from IDLE.
- `busy=1` in every state except IDLE.

## Timing
- Accept edge N: hold full from N+1. Shifter loads at edge N+1. `TX=0` and `busy=1` from N+2. `ready=1` from N+2.
- Each bit lasts exactly `BIT` cycles.
- Frame length is 10·`BIT` cycles, or 11·`BIT` with parity.
- Back-to-back: if a second byte is accepted before the first frame's stop bit ends, the next start bit begins on the cycle immediately after the last stop cycle.
- `busy` falls on the cycle after the last stop cycle when no byte is pending.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in, an even-parity bit is sent after bit 7, and the frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state or logic, and the frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg` holds:
  - the state encodings (IDLE, START, DATA, PARITY, STOP);
  - the derived `BIT`-count function, shared with the receiver;
  - the frame constants (8 data bits, 1 stop bit).
- Sub-module `uart_baud_cnt` is the bit-period counter. It has load/clear and emits a one-cycle `bit_end` pulse at count `BIT-1`. The receiver can reuse it.

## Test plan
All scenarios use `clk_frequency=1000`, `baud_rate=100`, so `BIT=10`.
- Reset: hold `reset=0` for 3 cycles → `TX=1`, `ready=1`, `busy=0`.
- Send 0x55 at edge N → `TX` low from N+2 for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then stop bit 1; `busy` falls at N+102.
- Send 0xA3, then 0x0F while `ready` is 1 during the first frame → the second start bit begins on the cycle right after the first stop bit, 100 cycles with no idle gap; the second frame's data bits are 1,1,1,1,0,0,0,0.
- `send` held high while `ready=0` → only the first byte is transmitted; the hold register is unchanged.
- Assert reset mid-DATA of 0x00 → `TX=1` from the next cycle, `ready=1`, and no further frame follows.
- With `UART_TX_PARITY_EN`: send 0x07 → the bit after data is 1 (three ones), the frame is 110 cycles; send 0x03 → the parity bit is 0.
